// File: rtl/div_unit_m.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in Execute.
// Holds the pipeline via stall_req while computing; killed by the Execute flush.
module div_unit_m #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  count;
  logic [XLEN-1:0]   quo, rem, dvsr, res_q;
  logic              neg_q, neg_r, want_rem;

  // Operand preparation at accept
  logic              is_signed, a_neg, b_neg, div_zero, ovf, accept;
  logic [XLEN-1:0]   a_abs, b_abs;

  always_comb begin
    is_signed = ~op[0];
    a_neg     = is_signed & src_a[XLEN-1];
    b_neg     = is_signed & src_b[XLEN-1];
    a_abs     = a_neg ? (~src_a + 1'b1) : src_a;
    b_abs     = b_neg ? (~src_b + 1'b1) : src_b;
    div_zero  = (src_b == '0);
    ovf       = is_signed & (src_a == INT_MIN) & (src_b == '1);
    accept    = (state == IDLE) & start & ~flush;
  end

  // One restoring step: the partial remainder is widened by one bit so a
  // divisor with its MSB set never overflows the trial subtraction.
  logic [XLEN:0]     shifted, diff;
  logic              fits;
  logic [XLEN-1:0]   quo_step, rem_step, q_fix, r_fix;

  always_comb begin
    shifted  = {rem, quo[XLEN-1]};
    diff     = shifted - {1'b0, dvsr};
    fits     = ~diff[XLEN];
    rem_step = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_step = {quo[XLEN-2:0], fits};
    q_fix    = neg_q ? (~quo_step + 1'b1) : quo_step;
    r_fix    = neg_r ? (~rem_step + 1'b1) : rem_step;
  end

  always_comb begin
    state_nxt = state;
    stall_req = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          stall_req = 1'b1;
          state_nxt = (div_zero | ovf) ? DONE : CALC;
        end
      end
      CALC: begin
        stall_req = 1'b1;
        if (count == LAST) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
      stall_req = 1'b0;
    end
    if (rst) stall_req = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      quo      <= '0;
      rem      <= '0;
      dvsr     <= '0;
      res_q    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      want_rem <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        want_rem <= op[1];
        neg_q    <= a_neg ^ b_neg;
        neg_r    <= a_neg;
        dvsr     <= b_abs;
        quo      <= a_abs;
        rem      <= '0;
        count    <= '0;
        if (div_zero)
          res_q <= op[1] ? src_a : '1;
        else if (ovf)
          res_q <= op[1] ? '0 : INT_MIN;
      end else if ((state == CALC) && !flush) begin
        quo   <= quo_step;
        rem   <= rem_step;
        count <= count + 1'b1;
        if (count == LAST)
          res_q <= want_rem ? r_fix : q_fix;
      end
    end
  end

  assign done   = (state == DONE);
  assign result = res_q;

endmodule

// File: tb/tb_div_unit_m.sv
// Scoreboard bench for div_unit_m: stimulus pushes expected result and done
// cycle; a negedge monitor pops and compares whenever done is seen.
module tb_div_unit_m;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        stall_req, done;
  logic [31:0] result;

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] val;
    int          at;
    string       name;
  } exp_t;

  exp_t sb[$];

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  div_unit_m #(.XLEN(32), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .flush     (flush),
    .stall_req (stall_req),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got result %h with no expected entry (cycle %0d)", result, cyc);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_result"}, result, e.val);
        chk({e.name, "_cycle"}, cyc, e.at);
      end
    end
  end

  task automatic idle();
    @(posedge clk); #1;
    start = 1'b0;
    flush = 1'b0;
  endtask

  // Issue one op: start held through the stall and the DONE cycle.
  task automatic issue(input string nm, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ex, input int lat,
                       input bit tog);
    int   n;
    exp_t e;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b1; op = o; src_a = a; src_b = b;
    n = cyc;
    e.val = ex; e.at = n + lat; e.name = nm;
    sb.push_back(e);
    #1 chk({nm, "_stall_accept"}, stall_req, 1);
    for (int i = 1; i < lat; i++) begin
      @(posedge clk); #1;
      if (tog) begin
        src_a = $urandom;
        src_b = $urandom;
      end
      #1 chk({nm, "_stall_calc"}, stall_req, 1);
    end
    @(posedge clk); #1;
    #1 chk({nm, "_stall_done"}, stall_req, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset_done", done, 0);
    chk("reset_result", result, 0);
    chk("reset_stall", stall_req, 0);

    // Normal path, then back-to-back signed ops (acceptance right after DONE)
    issue("divu_100_7",   OP_DIVU, 32'd100,        32'd7, 32'd14,         33, 1'b0);
    issue("div_m7_2",     OP_DIV,  32'hFFFF_FFF9,  32'd2, 32'hFFFF_FFFD,  33, 1'b0);
    issue("rem_m7_2",     OP_REM,  32'hFFFF_FFF9,  32'd2, 32'hFFFF_FFFF,  33, 1'b0);
    issue("remu_fff9_2",  OP_REMU, 32'hFFFF_FFF9,  32'd2, 32'd1,          33, 1'b0);
    idle();

    // Special cases resolved at accept
    issue("div_5_0",      OP_DIV,  32'd5,          32'd0,         32'hFFFF_FFFF, 1, 1'b0);
    issue("remu_5_0",     OP_REMU, 32'd5,          32'd0,         32'd5,         1, 1'b0);
    issue("div_ovf",      OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
    issue("rem_ovf",      OP_REM,  32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1, 1'b0);
    idle();

    // Flush at N+10 kills the op; a new DIVU at N+11 completes at N+44
    begin
      @(posedge clk); #1;
      start = 1'b1; op = OP_DIVU; src_a = 32'd1000; src_b = 32'd3;
      repeat (9) begin @(posedge clk); #1; end
      @(posedge clk); #1;
      flush = 1'b1;
      #1 chk("flush_stall", stall_req, 0);
    end
    issue("divu_9_3_after_flush", OP_DIVU, 32'd9, 32'd3, 32'd3, 33, 1'b0);
    idle();

    // Reset at N+5 mid-CALC
    begin
      @(posedge clk); #1;
      start = 1'b1; op = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
      repeat (4) begin @(posedge clk); #1; end
      @(posedge clk); #1;
      rst = 1'b1;
      #1 chk("rst_stall_during", stall_req, 0);
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      #1;
      chk("rst_done_after", done, 0);
      chk("rst_result_after", result, 0);
      chk("rst_stall_after", stall_req, 0);
    end

    // Operands toggled during CALC must not disturb captured values
    issue("divu_1000_10_tog", OP_DIVU, 32'd1000,       32'd10,        32'd100,       33, 1'b1);
    idle();
    issue("div_100_m7_tog",   OP_DIV,  32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 33, 1'b1);
    idle();
    issue("rem_m100_7_tog",   OP_REM,  32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFFE, 33, 1'b1);
    idle();

    // Full-width unsigned boundaries
    issue("divu_max_1",       OP_DIVU, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 33, 1'b0);
    issue("remu_max_msb",     OP_REMU, 32'hFFFF_FFFF,  32'h8000_0000, 32'h7FFF_FFFF, 33, 1'b0);
    issue("divu_8_c0",        OP_DIVU, 32'h8000_0000,  32'hC000_0000, 32'd0,         33, 1'b0);
    idle();

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1 chk("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
